// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial backing port.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_wb #(
  parameter int WORD_OFF_W = 3,
  parameter int SET_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_gnt,
  output logic [1:0]  state_dbg
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = 32 - SET_W - WORD_OFF_W - 2;
  localparam int SETS  = 1 << SET_W;
  localparam int DEPTH = 1 << (SET_W + WORD_OFF_W);
  localparam logic [WORD_OFF_W-1:0] OFF_ZERO = '0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVICT = 2'd1, S_REFILL = 2'd2} state_e;

  state_e                state_q;
  logic [WORD_OFF_W-1:0] cnt_q;
  logic [SETS-1:0]       valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q [SETS];
  logic [31:0]           data_q [DEPTH];
  logic [SET_W-1:0]      miss_idx_q;
  logic [TAG_W-1:0]      miss_tag_q;
  logic [31:0]           rd_data_q, mem_addr_q, mem_wdata_q;
  logic                  mem_req_q, mem_we_q;

  logic [WORD_OFF_W-1:0] req_word, cnt_nxt;
  logic [SET_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag, victim_tag;
  logic                  req, hit, idle_hit, idle_miss, last, refill_gnt;
  logic [31:0]           merged;
  logic                  unused_byte;

  assign req_word    = addr[2 +: WORD_OFF_W];
  assign req_idx     = addr[WORD_OFF_W+2 +: SET_W];
  assign req_tag     = addr[31 -: TAG_W];
  assign unused_byte = ^addr[1:0];

  assign req        = rd_req | (|wr_be);
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit   = (state_q == S_IDLE) && req && hit;
  assign idle_miss  = (state_q == S_IDLE) && req && !hit;
  assign last       = (cnt_q == {WORD_OFF_W{1'b1}});
  assign cnt_nxt    = cnt_q + 1'b1;
  assign refill_gnt = (state_q == S_REFILL) && mem_gnt;
  assign victim_tag = tag_q[miss_idx_q];

  // Stall is combinational in the detecting IDLE cycle and is forced low while in reset.
  assign miss      = rst & ((state_q != S_IDLE) | idle_miss);
  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign state_dbg = state_q;

  always_comb begin
    merged = data_q[{req_idx, req_word}];
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // Data and tag storage carry no reset; only valid/dirty qualify their contents.
  always_ff @(posedge clk) begin
    if (idle_hit && (|wr_be)) data_q[{req_idx, req_word}] <= merged;
    else if (refill_gnt)      data_q[{miss_idx_q, cnt_q}] <= mem_rdata;
    if (refill_gnt && last)   tag_q[miss_idx_q] <= miss_tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (idle_hit) begin
            if (rd_req)  rd_data_q <= data_q[{req_idx, req_word}];
            if (|wr_be)  dirty_q[req_idx] <= 1'b1;
          end else if (idle_miss) begin
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
            cnt_q      <= '0;
            mem_req_q  <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= S_EVICT;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx], req_idx, OFF_ZERO, 2'b00};
              mem_wdata_q <= data_q[{req_idx, OFF_ZERO}];
            end else begin
              state_q    <= S_REFILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag, req_idx, OFF_ZERO, 2'b00};
            end
          end
        end
        S_EVICT: begin
          if (mem_gnt) begin
            if (last) begin
              state_q     <= S_REFILL;
              cnt_q       <= '0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {miss_tag_q, miss_idx_q, OFF_ZERO, 2'b00};
              mem_wdata_q <= '0;
            end else begin
              cnt_q       <= cnt_nxt;
              mem_addr_q  <= {victim_tag, miss_idx_q, cnt_nxt, 2'b00};
              mem_wdata_q <= data_q[{miss_idx_q, cnt_nxt}];
            end
          end
        end
        S_REFILL: begin
          if (mem_gnt) begin
            if (last) begin
              state_q             <= S_IDLE;
              cnt_q               <= '0;
              mem_req_q           <= 1'b0;
              mem_addr_q          <= '0;
              valid_q[miss_idx_q] <= 1'b1;
              dirty_q[miss_idx_q] <= 1'b0;
            end else begin
              cnt_q      <= cnt_nxt;
              mem_addr_q <= {miss_tag_q, miss_idx_q, cnt_nxt, 2'b00};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (idle_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core's MEM-stage memory port and a word-wide backing memory.
- Drives the hazard unit's DCacheMiss input to stall the pipeline during line eviction and refill.
- Core-side timing matches the existing synchronous data RAM: read data is registered and appears the cycle after a hitting request.

Parameters:
- WORD_OFF_W, 3, log2 words per line (8 words = 32 B line)
- SET_W, 6, log2 number of sets (64 sets, 2 KiB data)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- addr  in  32  byte address from AluOutM
- rd_req  in  1  load in MEM stage
- wr_be  in  4  store byte enables (MemWriteM); nonzero means store
- wr_data  in  32  store data (StoreDataM), already lane-aligned
- rd_data  out  32  registered load word, valid the cycle after a hit
- miss  out  1  stall request to the hazard unit (DCacheMiss)
- mem_req  out  1  backing memory word request
- mem_we  out  1  1 = write word, 0 = read word
- mem_addr  out  32  word-aligned backing address
- mem_wdata  out  32  eviction data
- mem_rdata  in  32  refill data, valid with mem_gnt
- mem_gnt  in  1  one-cycle accept/complete pulse per word

Behaviour:
- Address split: [1:0] byte; [WORD_OFF_W+1:2] word; next SET_W bits index; remainder tag.
- Reset (rst=0, async): all valid and dirty bits 0; state IDLE; word counter 0; rd_data, mem_addr, mem_wdata = 0; mem_req, mem_we, miss = 0.
- States: IDLE, EVICT, REFILL.
- IDLE, request is (rd_req | |wr_be):
  - Hit (valid && tag match): miss=0.
  - Read hit: rd_data <= addressed word at the next edge.
  - Write hit: merge the bytes selected by wr_be at the next edge; set dirty.
  - Read and write together: the write is performed, and rd_data returns the pre-write word.
- IDLE, request misses:
  - miss=1 combinationally in the same cycle.
  - Next state is EVICT if the victim is valid && dirty, else REFILL. Counter cleared.
- IDLE with no request: miss=0, rd_data holds its value.
- EVICT:
  - mem_req=1, mem_we=1.
  - mem_addr={victim tag, index, counter, 2'b00}; mem_wdata = victim word[counter].
  - On mem_gnt: counter++. On the last word: go to REFILL, counter=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={request tag, index, counter, 2'b00}.
  - On mem_gnt: line word[counter] <= mem_rdata; counter++.
  - On the last word: write tag, valid=1, dirty=0; go to IDLE.
- miss stays 1 in every cycle of EVICT and REFILL. In the following IDLE cycle the held request hits and miss drops to 0.
- Minimum miss penalty with mem_gnt every cycle:
  - Clean miss: miss high for 1 + 2^WORD_OFF_W cycles (9).
  - Dirty miss: 1 + 2×2^WORD_OFF_W cycles (17).
- The core holds addr, rd_req, wr_be and wr_data stable while miss=1. The cache registers the miss index/tag at the miss edge and uses the registered copy thereafter.
- mem_gnt with mem_req=0 is ignored. mem_req and mem_addr hold steady until mem_gnt.
- Counter wraps only at line end. There are no partial-line transfers.
- Async reset mid-EVICT/REFILL aborts the transfer: mem_req drops immediately and the whole cache is invalidated. A partially written backing line is acceptable.
- Data/tag arrays need not be reset. Only the valid/dirty bits require reset.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - hit_cnt increments once per request accepted with miss=0.
  - miss_cnt increments once per IDLE miss detection, not per stalled cycle.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Cold read, addr 0x0000_0104, mem_rdata = mem_addr, mem_gnt every REFILL cycle -> mem_addr sequence 0x100..0x11C; miss high 9 cycles; rd_data = 0x0000_0104 one cycle after miss falls.
- Write hit to 0x104, wr_be=4'b0010, wr_data=0x0000_AB00 -> the following read of 0x104 returns 0x0000_AB04; no mem_req.
- Read 0x0000_0904 (same index, new tag) after the dirty write -> 8 EVICT writes to 0x100..0x11C, the word at 0x104 being 0x0000_AB04; then 8 REFILLs from 0x900..; miss high 17 cycles.
- Back-to-back read hits on 0x108, 0x10C, 0x100 -> miss stays 0; rd_data 0x108, 0x10C, 0x100 on consecutive cycles.
- mem_gnt delayed 3 cycles per word during refill -> mem_req and mem_addr hold stable; miss high 1 + 8×4 = 33 cycles; line data correct.
- rst pulsed low during the 4th refill word -> mem_req and miss fall asynchronously; a re-read of 0x104 misses again and refills fully.
